// File: rtl/call_request_register.sv
// Debounces hall/car buttons and latches each press until the car serves it.
// Optional REQ_CANCEL_EN: a re-press of a pending car call cancels it.
module call_request_register #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] button_up,
  input  logic [2:0] button_down,
  input  logic [3:0] button_in,
  input  logic [2:0] position,
  input  logic       open,
  input  logic [1:0] direction,
  output logic [2:0] req_up,
  output logic [2:0] req_down,
  output logic [3:0] req_in,
  output logic       any_req,
  output logic [3:0] pending_count
);

  localparam int unsigned NB = 10;
  localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

  // bit map: [2:0]=hall up, [5:3]=hall down, [9:6]=car
  logic [NB-1:0] btn;
  logic [7:0]    cnt_q [NB];
  logic [7:0]    cnt_d [NB];
  logic [NB-1:0] armed_q, armed_d;
  logic [NB-1:0] req_q, req_d;
  logic [NB-1:0] acc;
  logic [NB-1:0] clr;

  logic       svc;
  logic [1:0] f_idx;
  logic [1:0] dir_eff;
  logic       up_ok;
  logic       down_ok;
  logic [3:0] fmask;

  assign btn = {button_in, button_down, button_up};

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      cnt_d[i]   = cnt_q[i];
      armed_d[i] = armed_q[i];
      acc[i]     = 1'b0;
      if (!btn[i]) begin
        cnt_d[i]   = 8'd0;
        armed_d[i] = 1'b0;
      end else begin
        if (cnt_q[i] < DB)
          cnt_d[i] = cnt_q[i] + 8'd1;
        if (cnt_d[i] == DB && !armed_q[i]) begin
          acc[i]     = 1'b1;
          armed_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    svc     = !position[0] && (position != 3'b111) && open;
    f_idx   = position[2:1];
    dir_eff = (direction == 2'b11) ? 2'b00 : direction;
    up_ok   = (dir_eff == 2'b00) || (dir_eff == 2'b01);
    down_ok = (dir_eff == 2'b00) || (dir_eff == 2'b10);
    fmask   = 4'b0001 << f_idx;
    clr     = '0;
    if (svc) begin
      clr[9:6] = fmask;
      clr[2:0] = up_ok ? fmask[2:0] : 3'b000;
      clr[5:3] = down_ok ? fmask[3:1] : 3'b000;
    end
  end

  always_comb begin
    req_d = req_q | acc;
`ifdef REQ_CANCEL_EN
    req_d[9:6] = req_q[9:6] ^ acc[9:6];
`endif
    req_d = req_d & ~clr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++)
        cnt_q[i] <= 8'd0;
      armed_q <= '0;
      req_q   <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        cnt_q[i] <= cnt_d[i];
      armed_q <= armed_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    pending_count = 4'd0;
    for (int i = 0; i < NB; i++)
      pending_count = pending_count + 4'(req_q[i]);
  end

  assign req_up   = req_q[2:0];
  assign req_down = req_q[5:3];
  assign req_in   = req_q[9:6];
  assign any_req  = |req_q;

endmodule

// File: tb/tb_call_request_register.sv
// Directed-vector bench for call_request_register (DEBOUNCE_CYCLES = 2).
// Honours REQ_CANCEL_EN when predicting the car-call re-press result.
module tb_call_request_register;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] button_up;
  logic [2:0] button_down;
  logic [3:0] button_in;
  logic [2:0] position;
  logic       open;
  logic [1:0] direction;
  logic [2:0] req_up;
  logic [2:0] req_down;
  logic [3:0] req_in;
  logic       any_req;
  logic [3:0] pending_count;

  int n_vec = 0;
  int n_err = 0;

  call_request_register #(.DEBOUNCE_CYCLES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .button_up     (button_up),
    .button_down   (button_down),
    .button_in     (button_in),
    .position      (position),
    .open          (open),
    .direction     (direction),
    .req_up        (req_up),
    .req_down      (req_down),
    .req_in        (req_in),
    .any_req       (any_req),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    button_up   = '0;
    button_down = '0;
    button_in   = 4'b1111;
    position    = 3'b001;
    open        = 1'b0;
    direction   = 2'b00;
    tick(2);
    chk("rst_req_in", 16'(req_in), 16'h0);
    chk("rst_req_up", 16'(req_up), 16'h0);
    chk("rst_req_dn", 16'(req_down), 16'h0);
    chk("rst_any", 16'(any_req), 16'h0);
    chk("rst_cnt", 16'(pending_count), 16'h0);

    reset_n = 1'b1;
    tick(1);
    chk("rel_1edge", 16'(req_in), 16'h0);
    tick(1);
    chk("rel_2edge", 16'(req_in), 16'hf);
    chk("rel_cnt", 16'(pending_count), 16'd4);

    button_in = '0;
    reset_n   = 1'b0;
    tick(1);
    chk("mid_rst", 16'(pending_count), 16'd0);
    reset_n = 1'b1;

    button_up = 3'b010;
    tick(1);
    button_up = 3'b000;
    tick(2);
    chk("glitch", 16'(req_up), 16'h0);
    button_up = 3'b010;
    tick(2);
    chk("held_up", 16'(req_up), 16'h2);
    chk("held_any", 16'(any_req), 16'h1);
    button_up = 3'b000;
    tick(1);

    button_down = 3'b001;
    button_in   = 4'b0010;
    tick(2);
    button_down = '0;
    button_in   = '0;
    tick(1);
    chk("set_dn", 16'(req_down), 16'h1);
    chk("set_in", 16'(req_in), 16'h2);
    chk("set_cnt", 16'(pending_count), 16'd3);

    position = 3'b010;
    open     = 1'b0;
    tick(2);
    chk("door_shut", 16'(pending_count), 16'd3);

    position  = 3'b011;
    open      = 1'b1;
    direction = 2'b01;
    tick(5);
    chk("off_floor", 16'(req_in), 16'h2);
    chk("off_cnt", 16'(pending_count), 16'd3);

    position = 3'b010;
    tick(1);
    chk("svc_up", 16'(req_up), 16'h0);
    chk("svc_in", 16'(req_in), 16'h0);
    chk("svc_dn_keep", 16'(req_down), 16'h1);
    direction = 2'b10;
    tick(1);
    chk("svc_dn", 16'(req_down), 16'h0);
    chk("svc_any", 16'(any_req), 16'h0);

    position  = 3'b001;
    open      = 1'b0;
    direction = 2'b00;
    button_up = 3'b010;
    tick(2);
    button_up = '0;
    tick(1);
    chk("up_again", 16'(req_up), 16'h2);
    position  = 3'b010;
    open      = 1'b1;
    direction = 2'b11;
    tick(1);
    chk("dir11_clr", 16'(req_up), 16'h0);

    position  = 3'b001;
    open      = 1'b0;
    direction = 2'b00;
    button_in = 4'b0100;
    tick(1);
    position = 3'b100;
    open     = 1'b1;
    tick(1);
    chk("clr_beats_set", 16'(req_in), 16'h0);
    position = 3'b001;
    open     = 1'b0;
    tick(3);
    chk("no_reset_held", 16'(req_in), 16'h0);
    button_in = '0;
    tick(1);
    button_in = 4'b0100;
    tick(2);
    chk("repress", 16'(req_in), 16'h4);
    button_in = '0;
    tick(1);

    button_in = 4'b1000;
    tick(2);
    button_in = '0;
    tick(1);
    chk("car4_set", 16'(req_in), 16'hc);
    chk("car4_cnt", 16'(pending_count), 16'd2);
    button_in = 4'b1000;
    tick(2);
    button_in = '0;
    tick(1);
`ifdef REQ_CANCEL_EN
    chk("car4_cancel", 16'(req_in), 16'h4);
    chk("cancel_cnt", 16'(pending_count), 16'd1);
`else
    chk("car4_keep", 16'(req_in), 16'hc);
    chk("keep_cnt", 16'(pending_count), 16'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
